// File: rtl/hack_pkg.sv
// Shared types for the Hack CPU boot loader: FSM state encoding and word width.
// BOOT_CHECKSUM_EN adds the checksum trailer states to the enum.
package hack_pkg;

  localparam int BOOT_WORD_W = 16;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
`ifdef BOOT_CHECKSUM_EN
    CSUM_HI = 4'd5,
    CSUM_LO = 4'd6,
`endif
    RUN     = 4'd7,
    ERROR   = 4'd8
  } boot_state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs a high/low byte pair into one instruction word; word_valid is a registered
// one-cycle pulse in the cycle after the low byte is loaded.
module boot_word_assembler
  import hack_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hi_load,
  input  logic                   lo_load,
  input  logic [7:0]             byte_data,
  output logic                   word_valid,
  output logic [BOOT_WORD_W-1:0] word
);

  logic [7:0] hi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q       <= 8'h00;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= lo_load;
      if (hi_load) hi_q <= byte_data;
      if (lo_load) word <= {hi_q, byte_data};
    end
  end

endmodule

// File: rtl/rom_boot_loader.sv
// Hack CPU boot sequencer: loads a length-prefixed word image from a byte stream into
// instruction ROM, then releases CPU reset. BOOT_CHECKSUM_EN adds a 16-bit sum trailer.
//
// state   | meaning
// IDLE    | after reset, CPU held, waiting for start
// LEN_HI  | waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte, length checked on transfer
// DATA_HI | waiting for high byte of the next word
// DATA_LO | waiting for low byte; holds through the final word's write cycle
// CSUM_HI | waiting for checksum high byte (BOOT_CHECKSUM_EN only)
// CSUM_LO | waiting for checksum low byte, compared on transfer
// RUN     | image loaded, CPU released
// ERROR   | bad length or checksum, CPU held until start
module rom_boot_loader
  import hack_pkg::*;
#(
  parameter int ROM_AW = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   rom_we,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic [BOOT_WORD_W-1:0] rom_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ROM_AW;

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t AFTER_DATA = CSUM_HI;
`else
  localparam boot_state_t AFTER_DATA = RUN;
`endif

  boot_state_t state, state_nxt;

  logic                   xfer;
  logic                   start_ok;
  logic [7:0]             len_hi_q;
  logic [15:0]            len_n;
  logic                   too_long;
  logic [15:0]            words_left;
  logic                   last_pending;
  logic                   word_valid;
  logic [BOOT_WORD_W-1:0] word;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]             csum_hi_q;
  logic [BOOT_WORD_W-1:0] csum_acc;
`endif

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state == IDLE || state == RUN || state == ERROR);
  assign len_n    = {len_hi_q, in_data};
  assign too_long = {1'b0, len_n} > MAX_WORDS;

  boot_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .hi_load    (state == DATA_HI && xfer),
    .lo_load    (state == DATA_LO && xfer),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  assign rom_we    = word_valid;
  assign rom_wdata = word;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN, ERROR: if (start) state_nxt = LEN_HI;
      LEN_HI:  if (xfer) state_nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_n == 16'd0) state_nxt = AFTER_DATA;
          else if (too_long)  state_nxt = ERROR;
          else                state_nxt = DATA_HI;
        end
      end
      DATA_HI: if (xfer) state_nxt = DATA_LO;
      DATA_LO: begin
        if (last_pending)                          state_nxt = AFTER_DATA;
        else if (xfer && words_left != 16'd1)      state_nxt = DATA_HI;
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM_HI: if (xfer) state_nxt = CSUM_LO;
      CSUM_LO: if (xfer) state_nxt = ({csum_hi_q, in_data} == csum_acc) ? RUN : ERROR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI: in_ready = 1'b1;
      // The final word's write cycle is spent in DATA_LO; nothing more is taken then.
      DATA_LO: in_ready = !last_pending;
`ifdef BOOT_CHECKSUM_EN
      CSUM_HI, CSUM_LO: in_ready = 1'b1;
`endif
      RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      ERROR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi_q     <= 8'h00;
      words_left   <= 16'd0;
      last_pending <= 1'b0;
      rom_addr     <= '0;
    end else begin
      if (start_ok) begin
        words_left <= 16'd0;
        rom_addr   <= '0;
      end
      if (state == LEN_HI && xfer) len_hi_q <= in_data;
      if (state == LEN_LO && xfer) words_left <= len_n;
      if (state == DATA_LO && xfer) begin
        words_left   <= words_left - 16'd1;
        last_pending <= (words_left == 16'd1);
      end else begin
        last_pending <= 1'b0;
      end
      // The final word leaves the address at N-1, so a full-size image never wraps.
      if (word_valid && !last_pending) rom_addr <= rom_addr + ROM_AW'(1);
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_hi_q <= 8'h00;
      csum_acc  <= '0;
    end else begin
      if (start_ok)                csum_acc  <= '0;
      else if (word_valid)         csum_acc  <= csum_acc + word;
      if (state == CSUM_HI && xfer) csum_hi_q <= in_data;
    end
  end
`endif

endmodule
